// File: rtl/audio_tone_player_pkg.sv
// Shared constants for the tone player: note frequencies, divider states and
// I2S frame timing (bit positions within the free-running frame counter).
package audio_tone_player_pkg;

  localparam logic [31:0] NOTE_C       = 32'd262;
  localparam logic [31:0] NOTE_D       = 32'd294;
  localparam logic [31:0] NOTE_E       = 32'd330;
  localparam logic [31:0] NOTE_F       = 32'd349;
  localparam logic [31:0] NOTE_G       = 32'd392;
  localparam logic [31:0] NOTE_A       = 32'd440;
  localparam logic [31:0] NOTE_B       = 32'd494;
  localparam logic [31:0] NOTE_HC      = 32'd524;
  localparam logic [31:0] NOTE_HD      = 32'd588;
  localparam logic [31:0] NOTE_HE      = 32'd660;
  localparam logic [31:0] NOTE_HF      = 32'd698;
  localparam logic [31:0] NOTE_HG      = 32'd784;
  localparam logic [31:0] NOTE_HA      = 32'd880;
  localparam logic [31:0] NOTE_HB      = 32'd988;
  localparam logic [31:0] NOTE_SILENCE = 32'd50_000_000;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int FRAME_BITS  = 9;
  localparam int MCLK_BIT    = 1;
  localparam int SCK_BIT     = 2;
  localparam int LRCK_BIT    = 8;
  localparam int SAMPLE_BITS = 16;
  localparam int DELAY_BITS  = 1;

  function automatic logic is_silent(input logic [31:0] tone, input logic [31:0] max_tone);
    return (tone == 32'd0) || (tone > max_tone);
  endfunction

endpackage

// File: rtl/audio_tone_player_tone_square_gen.sv
// One audio channel: converts a tone in Hz to a half-period by 32-step restoring
// division, then toggles a +/-AMP square wave every half-period clocks.
module tone_square_gen
  import audio_tone_player_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned MAX_TONE = 20000,
  parameter logic [15:0] AMP      = 16'h2000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   tone_in,
  output logic signed [SAMPLE_BITS-1:0] sample
);

  localparam logic [31:0] DIVIDEND = 32'(CLK_FREQ / 2);

  div_state_e  state_q, state_d;
  logic [31:0] tone_lat_q, tone_lat_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] half_period_q, half_period_d;
  logic [31:0] tog_cnt_q, tog_cnt_d;
  logic        phase_q, phase_d;
  logic [32:0] rem_sh, diff;
  logic        load;
  logic [31:0] load_val;

  always_comb begin
    state_d       = state_q;
    tone_lat_d    = tone_lat_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    bit_cnt_d     = bit_cnt_q;
    half_period_d = half_period_q;
    tog_cnt_d     = tog_cnt_q;
    phase_d       = phase_q;
    load          = 1'b0;
    load_val      = half_period_q;
    rem_sh        = {rem_q, quo_q[31]};
    diff          = rem_sh - {1'b0, tone_lat_q};

    case (state_q)
      DIV_IDLE: begin
        if (tone_in != tone_lat_q) begin
          tone_lat_d = tone_in;
          if (is_silent(tone_in, 32'(MAX_TONE))) begin
            load     = 1'b1;
            load_val = 32'd0;
          end else begin
            state_d   = DIV_RUN;
            rem_d     = 32'd0;
            quo_d     = DIVIDEND;
            bit_cnt_d = 5'd0;
          end
        end
      end
      DIV_RUN: begin
        // quo_q doubles as the dividend shift register: each step shifts in one quotient bit
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        load     = 1'b1;
        load_val = quo_q;
        state_d  = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    // a new half-period restarts the count but keeps the current phase
    if (load) begin
      half_period_d = load_val;
      tog_cnt_d     = 32'd0;
    end else if (half_period_q == 32'd0) begin
      tog_cnt_d = 32'd0;
    end else if (tog_cnt_q == half_period_q - 32'd1) begin
      tog_cnt_d = 32'd0;
      phase_d   = ~phase_q;
    end else begin
      tog_cnt_d = tog_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= DIV_IDLE;
      tone_lat_q    <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      bit_cnt_q     <= '0;
      half_period_q <= '0;
      tog_cnt_q     <= '0;
      phase_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      tone_lat_q    <= tone_lat_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      bit_cnt_q     <= bit_cnt_d;
      half_period_q <= half_period_d;
      tog_cnt_q     <= tog_cnt_d;
      phase_q       <= phase_d;
    end
  end

  assign sample = (half_period_q == 32'd0) ? '0 :
                  (phase_q ? $signed(AMP) : -$signed(AMP));

endmodule

// File: rtl/audio_tone_player.sv
// Stereo square-wave tone player driving a Pmod I2S DAC; the 9-bit frame counter
// supplies mclk/sck/lrck directly and paces the MSB-first serial data.
module audio_tone_player
  import audio_tone_player_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned MAX_TONE = 20000,
  parameter logic [15:0] AMP      = 16'h2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] toneL,
  input  logic [31:0] toneR,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin
);

  logic signed [SAMPLE_BITS-1:0] smp_l, smp_r;
  logic signed [SAMPLE_BITS-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d, word;
  logic [FRAME_BITS-1:0]         cnt_q, cnt_d;
  logic                          sdin_q, sdin_d;
  logic [4:0]                    slot;
  logic [3:0]                    bit_idx;

  tone_square_gen #(.CLK_FREQ(CLK_FREQ), .MAX_TONE(MAX_TONE), .AMP(AMP)) u_left (
    .clk     (clk),
    .rst_n   (rst),
    .tone_in (toneL),
    .sample  (smp_l)
  );

  tone_square_gen #(.CLK_FREQ(CLK_FREQ), .MAX_TONE(MAX_TONE), .AMP(AMP)) u_right (
    .clk     (clk),
    .rst_n   (rst),
    .tone_in (toneR),
    .sample  (smp_r)
  );

  always_comb begin
    cnt_d      = cnt_q + 9'd1;
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    sdin_d     = sdin_q;
    slot       = cnt_d[LRCK_BIT-1:SCK_BIT+1];
    bit_idx    = 4'(5'(SAMPLE_BITS) - slot);
    word       = cnt_d[LRCK_BIT] ? sample_r_q : sample_l_q;

    if (cnt_q == '1) begin
      sample_l_d = smp_l;
      sample_r_d = smp_r;
    end

    // next bit is launched on the sck falling edge; slot 0 is the I2S one-bit delay
    if (cnt_q[SCK_BIT:0] == '1) begin
      if (slot >= 5'(DELAY_BITS) && slot < 5'(DELAY_BITS + SAMPLE_BITS))
        sdin_d = word[bit_idx];
      else
        sdin_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      sdin_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      sdin_q     <= sdin_d;
    end
  end

  assign audio_mclk = cnt_q[MCLK_BIT];
  assign audio_sck  = cnt_q[SCK_BIT];
  assign audio_lrck = cnt_q[LRCK_BIT];
  assign audio_sdin = sdin_q;

endmodule

// File: tb/tb_audio_tone_player.sv
// Randomized bench for audio_tone_player against an event-level model of tone
// loads, square-wave phase and the I2S frame contents.
module tb_audio_tone_player;
  import audio_tone_player_pkg::*;

  localparam longint CLK_HZ  = 100000000;
  localparam longint MAXT    = 20000;
  localparam logic [15:0] AMP_P = 16'h2000;
  localparam logic [15:0] AMP_N = 16'hE000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] tone_l, tone_r;
  logic        audio_mclk, audio_lrck, audio_sck, audio_sdin;

  audio_tone_player dut (
    .clk        (clk),
    .rst        (rst),
    .toneL      (tone_l),
    .toneR      (tone_r),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // model state: edge counter since reset release, per-channel load schedule and wave regime
  longint      n;
  longint      lat[2], free_at[2], load_at[2], pend_val[2], t0[2], hp[2];
  bit          pend[2], ph0[2];
  logic [15:0] wl, wr;

  function automatic bit silent(input longint t);
    return (t == 0) || (t > MAXT);
  endfunction

  function automatic bit phase_at(input int ch, input longint e);
    if (hp[ch] == 0) return ph0[ch];
    return ph0[ch] ^ bit'(((e - t0[ch]) / hp[ch]) & 1);
  endfunction

  function automatic logic [15:0] sample_at(input int ch, input longint e);
    if (hp[ch] == 0) return 16'h0000;
    return phase_at(ch, e) ? AMP_P : AMP_N;
  endfunction

  task automatic model_reset;
    n = 0;
    wl = '0;
    wr = '0;
    for (int ch = 0; ch < 2; ch++) begin
      lat[ch] = 0; free_at[ch] = 0; load_at[ch] = 0; pend_val[ch] = 0;
      t0[ch] = 0; hp[ch] = 0; pend[ch] = 0; ph0[ch] = 0;
    end
  endtask

  task automatic do_load(input int ch, input longint v);
    ph0[ch] = phase_at(ch, n - 1);
    t0[ch]  = n;
    hp[ch]  = v;
  endtask

  task automatic model_step;
    longint tin[2];
    n++;
    tin[0] = longint'(tone_l);
    tin[1] = longint'(tone_r);
    if (n % 512 == 0) begin
      wl = sample_at(0, n - 1);
      wr = sample_at(1, n - 1);
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (pend[ch] && n == load_at[ch]) begin
        do_load(ch, pend_val[ch]);
        pend[ch] = 0;
      end else if (n >= free_at[ch] && tin[ch] != lat[ch]) begin
        lat[ch] = tin[ch];
        if (silent(tin[ch])) begin
          do_load(ch, 0);
        end else begin
          pend[ch]     = 1;
          load_at[ch]  = n + 33;
          pend_val[ch] = (CLK_HZ / 2) / tin[ch];
          free_at[ch]  = n + 34;
        end
      end
    end
  endtask

  task automatic check_outputs;
    longint      c, k;
    logic [15:0] w;
    logic        lr, sd;
    c  = n % 512;
    k  = (c >> 3) & 31;
    lr = c[8];
    w  = lr ? wr : wl;
    sd = (k >= 1 && k <= 16) ? w[16 - k] : 1'b0;
    chk("pins", {audio_mclk, audio_sck, audio_lrck, audio_sdin}, {c[1], c[2], lr, sd});
    chk("hp_l", dut.u_left.half_period_q, hp[0]);
    chk("hp_r", dut.u_right.half_period_q, hp[1]);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
    end
  endtask

  function automatic logic [31:0] rand_tone();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return 32'd0;
      1:       return NOTE_SILENCE;
      2:       return $urandom_range(20001, 60000);
      3:       return 32'(MAXT);
      default: return $urandom_range(9000, 20000);
    endcase
  endfunction

  initial begin
    tone_l = NOTE_SILENCE;
    tone_r = NOTE_SILENCE;
    model_reset();
    #12;
    chk("rst_pins", {audio_mclk, audio_sck, audio_lrck, audio_sdin}, 4'b0000);
    chk("rst_hp_l", dut.u_left.half_period_q, 0);
    @(negedge clk);
    rst = 1'b1;
    run(1100);

    tone_l = NOTE_A;
    run(33);
    chk("hp440_early", dut.u_left.half_period_q, 0);
    run(1);
    chk("hp440", dut.u_left.half_period_q, 113636);
    run(200);

    tone_r = NOTE_C;
    tone_l = NOTE_D;
    run(34);
    chk("hp262_r", dut.u_right.half_period_q, 190839);
    chk("hp294_l", dut.u_left.half_period_q, 170068);
    run(100);

    tone_l = NOTE_C;
    run(10);
    tone_l = NOTE_E;
    run(24);
    chk("hp262_first", dut.u_left.half_period_q, 190839);
    run(33);
    chk("hp330_early", dut.u_left.half_period_q, 190839);
    run(1);
    chk("hp330_last", dut.u_left.half_period_q, 151515);

    tone_l = 32'(MAXT);
    tone_r = 32'd12500;
    run(3000);

    for (int it = 0; it < 14; it++) begin
      tone_l = rand_tone();
      tone_r = rand_tone();
      if ($urandom_range(0, 3) == 0) run($urandom_range(1, 40));
      else run($urandom_range(500, 4000));
    end

    tone_l = 32'd18000;
    run(10);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_pins", {audio_mclk, audio_sck, audio_lrck, audio_sdin}, 4'b0000);
    chk("async_rst_hp_l", dut.u_left.half_period_q, 0);
    chk("async_rst_hp_r", dut.u_right.half_period_q, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    run(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/audio_tone_player.md
Name: audio_tone_player

Overview:
- Audio back end that consumes the 32-bit toneL/toneR frequency words (Hz) from the song/demo lookup blocks and drives the Pmod I2S stereo DAC.
- Per channel it computes a half-period by sequential division, generates a ±AMP square wave and serializes both 16-bit samples onto mclk/lrck/sck/sdin.
- Sits between the music lookup logic and the top-level audio pins.

Parameters:
- CLK_FREQ, 100000000, system clock in Hz.
- MAX_TONE, 20000, tone values above this (including the 50000000 silence word) or equal to 0 are treated as silence.
- AMP, 16'h2000, square-wave amplitude. Samples are +AMP or −AMP in two's complement.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- toneL  in  32  left tone frequency in Hz.
- toneR  in  32  right tone frequency in Hz.
- audio_mclk  out  1  DAC master clock, clk/4.
- audio_lrck  out  1  left/right word clock, clk/512. 0 selects left, 1 selects right.
- audio_sck  out  1  serial bit clock, clk/8.
- audio_sdin  out  1  serial data, MSB first.

Behaviour:
- Reset (rst=0, asynchronous): every register goes to 0.
  - All outputs are 0.
  - Latched tones are 0, so both channels are silent with half-period 0.
  - Dividers are IDLE and phases are 0.
- Per-channel divider FSM: IDLE → DIV → DONE → IDLE.
  - IDLE, tone_in ≠ tone_lat: latch tone_in into tone_lat.
    - If the tone is silent: half_period ← 0 and stay in IDLE.
    - Otherwise: go to DIV.
  - DIV: 32-cycle restoring division of CLK_FREQ/2 by tone_lat. Quotient is floored, 32 bits.
  - DONE: load half_period, clear the toggle counter (phase bit kept), return to IDLE.
  - Latency from a tone change to the new half_period is 34 cycles: 1 latch + 32 divide + 1 load.
  - A tone change during DIV is ignored until IDLE; it then triggers a new divide, so the last value wins.
  - Until DONE the previous half_period keeps being used.
  - An unchanged tone never re-triggers a divide.
- Square generator:
  - If half_period == 0, the sample is 0 and the counter is held at 0.
  - Otherwise the counter counts 0..half_period−1. At half_period−1 it wraps and toggles the phase.
  - Sample is +AMP when phase=1 and −AMP when phase=0.
- Serializer, driven by a free-running 9-bit counter cnt:
  - audio_mclk = cnt[1], audio_sck = cnt[2], audio_lrck = cnt[8].
  - When cnt wraps 511→0, both channel samples are captured into sample_l and sample_r. The captured pair is held for the whole frame.
  - Within each lrck half, k = cnt[7:3] (0..31) and sdin changes when cnt[2:0]==0 (sck falling edge).
    - k=0: sdin=0 (one-bit I2S delay).
    - k=1..16: sdin = bit (16−k) of sample_l when lrck=0, or of sample_r when lrck=1.
    - k=17..31: sdin=0.
  - audio_sdin is registered.
- Left and right are fully independent. Simultaneous changes of both tones divide in parallel.
- Reset asserted mid-frame or mid-divide aborts immediately to the reset state. After release, the frame restarts at cnt=0.

Decomposition:
- Shared package holds:
  - Note constants: c..hb, and the silence word 50000000.
  - Divider state encoding: IDLE/DIV/DONE.
  - Serializer timing constants: MCLK, SCK and LRCK bit indices, 16 data bits, 1 delay bit.
- One sub-module, tone_square_gen, contains the divider FSM and the toggle counter. It is instantiated once per channel.
- The serializer stays in the top module.

Test Plan:
1. Release reset with toneL=toneR=50000000 → sdin stays 0 for all frames. Check lrck period 512 cycles, sck period 8, mclk period 4.
2. Set toneL=440 → half_period=113636 exactly 34 cycles later. Left phase then toggles every 113636 cycles, and left words alternate 0x2000/0xE000 while right words are 0.
3. Set toneR=262 and toneL=294 in the same cycle → right half_period=190839 and left half_period=170068, both valid 34 cycles later.
4. Set toneL to 262, then to 330 ten cycles later (mid-divide) → first result 190839 loads at cycle 34. A second divide then loads 151515 at cycle 68.
5. Force a captured left sample of 0x2000 → in the lrck=0 half: k=0 gives 0, k=1..16 gives 0,0,1 then thirteen 0s, k≥17 gives 0.
6. Assert rst low mid-frame during DIV → all outputs 0 asynchronously. After release the old tone re-divides, the first frame starts at cnt=0, and no stale sample is shifted.
